router_ingress_arbiter: RTL and testbench

//  Shares one 4-output simple router among NUM_REQ upstream requesters. Each requester offers

---
 rtl/router_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/router_ingress_arbiter.sv | 135 +++++++++++++
 tb/tb_router_ingress_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants and the ingress arbiter state type.
package router_pkg;

    localparam int ROUTER_ADDR_W  = 2;
    localparam int ROUTER_NUM_OUT = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after i_ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin : search
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any = 1'b1;
                o_idx = IW'(j);
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Shares one 4-output router among NUM_REQ requesters: round-robin grant, burst lock,
// and a registered din/din_en/addr drive stage.
module router_ingress_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*ROUTER_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           din,
    output logic                            din_en,
    output logic [ROUTER_ADDR_W-1:0]        addr,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int   IDX_W    = $clog2(NUM_REQ);
    localparam int   CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic ST_IDLE  = ARB_IDLE;
    localparam logic ST_BURST = ARB_BURST;

    logic                     r_state;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [IDX_W-1:0]         r_lock;
    logic [ROUTER_ADDR_W-1:0] r_burst_addr;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic                     r_cooldown;
    logic [DATA_WIDTH-1:0]    r_din;
    logic                     r_din_en;
    logic [ROUTER_ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]         r_grant_id;

    logic [NUM_REQ-1:0]       w_arb_req;
    logic [NUM_REQ-1:0]       w_arb_grant;
    logic [IDX_W-1:0]         w_arb_idx;
    logic                     w_arb_any;
    logic                     w_in_burst;
    logic [IDX_W-1:0]         w_sel_idx;
    logic                     w_sel_last;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [ROUTER_ADDR_W-1:0] w_sel_addr;
    logic [ROUTER_ADDR_W-1:0] w_out_addr;
    logic                     w_xfer;
    logic [CNT_W-1:0]         w_beat_next;
    logic                     w_release;
    logic [IDX_W-1:0]         w_next_ptr;

    assign w_in_burst = (r_state == ST_BURST);

    // The cycle after a release is a cooldown: no new grant until arbitration resumes.
    assign w_arb_req = (!w_in_burst && !r_cooldown) ? req_valid : '0;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // Handshake: a beat moves when req_valid[i] & req_ready[i]; ready is one-hot or zero,
    // never depends on valid in BURST, and is forced low while reset is high.
    always_comb begin
        req_ready = '0;
        if (!reset) begin
            if (w_in_burst) begin
                req_ready[r_lock] = 1'b1;
            end else begin
                req_ready = w_arb_grant;
            end
        end
    end

    assign w_sel_idx   = w_in_burst ? r_lock : w_arb_idx;
    assign w_sel_last  = req_last[w_sel_idx];
    assign w_sel_data  = req_data[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_addr  = req_addr[w_sel_idx*ROUTER_ADDR_W +: ROUTER_ADDR_W];
    assign w_out_addr  = w_in_burst ? r_burst_addr : w_sel_addr;
    assign w_xfer      = !reset && (w_in_burst ? req_valid[r_lock] : w_arb_any);
    assign w_beat_next = (w_in_burst ? r_beat_cnt : '0) + CNT_W'(1);
    assign w_release   = w_xfer && (w_sel_last || (w_beat_next == CNT_W'(MAX_BURST)));
    assign w_next_ptr  = (w_sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_lock       <= '0;
            r_burst_addr <= '0;
            r_beat_cnt   <= '0;
            r_cooldown   <= 1'b0;
            r_din        <= '0;
            r_din_en     <= 1'b0;
            r_addr       <= '0;
            r_grant_id   <= '0;
        end else begin
            r_din_en   <= w_xfer;
            r_din      <= w_xfer ? w_sel_data : '0;
            r_addr     <= w_xfer ? w_out_addr : '0;
            r_cooldown <= w_release;
            if (w_xfer) begin
                r_grant_id <= w_sel_idx;
            end
            if (w_release) begin
                r_state    <= ST_IDLE;
                r_rr_ptr   <= w_next_ptr;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= w_beat_next;
                if (!w_in_burst) begin
                    r_state      <= ST_BURST;
                    r_lock       <= w_sel_idx;
                    r_burst_addr <= w_sel_addr;
                end
            end
        end
    end

    assign din      = r_din;
    assign din_en   = r_din_en;
    assign addr     = r_addr;
    assign grant_id = r_grant_id;
    assign busy     = w_in_burst;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Bench for router_ingress_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grants, bursts and the registered router drive.
module tb_router_ingress_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR*2-1:0]   req_addr;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     din;
    logic              din_en;
    logic [1:0]        addr;
    logic [IW-1:0]     grant_id;
    logic              busy;

    // clock / reset
    always #5 clk = ~clk;

    router_ingress_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_last  (req_last),
        .req_ready (req_ready),
        .din       (din),
        .din_en    (din_en),
        .addr      (addr),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: owner of the current burst (-1 = none), beats taken in it,
    // round-robin start point and the one-cycle pause after each finished burst
    int            m_owner;
    int            m_beats;
    int            m_ptr;
    bit            m_pause;
    logic [1:0]    m_baddr;
    bit            e_en;
    int            e_gid;
    bit            chk_out;
    logic [DW+1:0] exp_q[$];

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_pause = 1'b0;
        m_baddr = '0;
        e_en    = 1'b0;
        e_gid   = 0;
        exp_q.delete();
    endtask

    // driver tasks
    task automatic drive(input int i, input bit v, input bit last, input logic [DW-1:0] d,
                         input logic [1:0] a);
        req_valid[i]        = v;
        req_last[i]         = last;
        req_data[i*DW +: DW] = d;
        req_addr[i*2 +: 2]   = a;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        req_addr  = '0;
    endtask

    // one clock: check outputs and ready at the falling edge, advance the model at the rising edge
    task automatic step(input bit rst);
        int            idx;
        bit            xfer;
        int            b;
        logic [1:0]    ba;
        logic [NR-1:0] er;
        logic [DW+1:0] beat;
        @(negedge clk);
        reset = rst;
        #1;
        if (chk_out) begin
            check("din_en", 64'(din_en), 64'(e_en));
            check("busy", 64'(busy), 64'(m_owner >= 0));
            check("grant_id", 64'(grant_id), 64'(e_gid));
            if (e_en) begin
                if (exp_q.size() > 0) begin
                    beat = exp_q.pop_front();
                    check("beat", 64'({addr, din}), 64'(beat));
                end else begin
                    check("beat_expected", 64'(0), 64'(1));
                end
            end else begin
                check("din_idle", 64'(din), 64'(0));
                check("addr_idle", 64'(addr), 64'(0));
            end
        end
        er  = '0;
        idx = -1;
        if (!rst && !m_pause) begin
            if (m_owner >= 0) begin
                idx = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (idx < 0 && req_valid[(m_ptr + k) % NR]) idx = (m_ptr + k) % NR;
                end
            end
            if (idx >= 0) er[idx] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(er));
        xfer = (idx >= 0) ? req_valid[idx] : 1'b0;
        @(posedge clk);
        chk_out = 1'b1;
        if (rst) begin
            model_reset();
        end else begin
            m_pause = 1'b0;
            e_en    = xfer;
            if (xfer) begin
                b  = ((m_owner >= 0) ? m_beats : 0) + 1;
                ba = (m_owner >= 0) ? m_baddr : req_addr[idx*2 +: 2];
                exp_q.push_back({ba, req_data[idx*DW +: DW]});
                e_gid = idx;
                if (req_last[idx] || b == MB) begin
                    m_owner = -1;
                    m_beats = 0;
                    m_ptr   = (idx + 1) % NR;
                    m_pause = 1'b1;
                end else begin
                    if (m_owner < 0) begin
                        m_owner = idx;
                        m_baddr = ba;
                    end
                    m_beats = b;
                end
            end
        end
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        chk_out = 1'b0;
        clear_all();
        model_reset();

        // reset held two cycles with every requester valid
        req_valid = '1;
        req_last  = '1;
        step(1);
        step(1);

        // single beat from requester 0
        clear_all();
        drive(0, 1, 1, 32'hA5A5_0001, 2'd2);
        step(0);
        clear_all();
        step(0);
        step(0);

        // round robin with everyone valid and last
        step(1);
        for (int i = 0; i < NR; i++) drive(i, 1, 1, $urandom, 2'($urandom_range(0, 3)));
        repeat (10) step(0);
        clear_all();
        step(0);

        // burst lock: req1 three beats, req2 waiting
        step(1);
        drive(2, 1, 1, 32'h2222_0000, 2'd0);
        drive(1, 1, 0, 32'h1111_0001, 2'd3);
        step(0);
        drive(1, 1, 0, 32'h1111_0002, 2'd1);
        step(0);
        drive(1, 1, 1, 32'h1111_0003, 2'd0);
        step(0);
        drive(1, 0, 0, 32'h0, 2'd0);
        repeat (4) step(0);
        clear_all();
        step(0);

        // forced release after MAX_BURST beats, then another requester joins
        step(1);
        for (int n = 0; n < 12; n++) begin
            drive(0, 1, 0, 32'h0C00_0000 + n, 2'($urandom_range(0, 3)));
            if (n == 9) drive(1, 1, 1, 32'h0B0B_0001, 2'd1);
            step(0);
        end
        clear_all();
        step(0);

        // reset in the middle of a burst, then requester 3 single beat
        step(1);
        drive(0, 1, 0, 32'hDD00_0001, 2'd1);
        step(0);
        drive(0, 1, 0, 32'hDD00_0002, 2'd2);
        step(1);
        clear_all();
        drive(3, 1, 1, 32'h3333_0003, 2'd3);
        step(0);
        clear_all();
        step(0);

        // random traffic with occasional reset
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NR; i++) begin
                drive(i, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), $urandom,
                      2'($urandom_range(0, 3)));
            end
            step($urandom_range(0, 99) == 0);
        end
        clear_all();
        step(0);
        step(0);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
